// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode definitions: FSM states and instruction sizing.
// Imported by the fetch stage and by the decoder.
package instruction_fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } if_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, single outstanding imem request,
// registered instruction output with valid/ready and branch squash.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   branch_valid,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    instr_pc
);

  if_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  squash_q, squash_d;
  logic                  req_q, req_d;
  logic [PC_WIDTH-1:0]   addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]   ipc_q, ipc_d;

  logic [PC_WIDTH-1:0]   tgt;
  logic [PC_WIDTH-1:0]   pc_next;
  logic                  ack;
  logic                  unused_tgt_lo;

  // Redirects are always word aligned; low target bits are dropped.
  assign tgt           = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign unused_tgt_lo = ^branch_target[1:0];
  assign pc_next       = pc_q + PC_WIDTH'(PC_STEP);
  assign ack           = imem_ack & req_q;

  // Next-state: branch outranks ack and ready in every state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    req_d    = req_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        if (branch_valid) begin
          pc_d   = tgt;
          addr_d = tgt;
        end else begin
          addr_d = pc_q;
        end
      end
      FETCH: begin
        if (branch_valid) begin
          pc_d = tgt;
          if (ack) begin
            squash_d = 1'b0;
            req_d    = 1'b1;
            addr_d   = tgt;
          end else begin
            squash_d = 1'b1;
          end
        end else if (ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
            req_d    = 1'b1;
            addr_d   = pc_q;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_valid) begin
          pc_d    = tgt;
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = tgt;
          state_d = FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_next;
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_next;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch.
// Two instances: RESET_PC=0 and RESET_PC=0xFFFF_FFFC.
module tb_instruction_fetch;

  logic        clk;
  logic        rst0_n, rst1_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        ack0, ack1;
  logic [31:0] rd0, rd1;
  logic        br0, br1;
  logic [31:0] tg0, tg1;
  logic        v0, v1;
  logic        rdy0, rdy1;
  logic [31:0] ins0, ins1;
  logic [31:0] ipc0, ipc1;

  int tests;
  int fails;

  instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .reset_n(rst0_n),
    .imem_req(req0), .imem_addr(addr0),
    .imem_ack(ack0), .imem_rdata(rd0),
    .branch_valid(br0), .branch_target(tg0),
    .instr_valid(v0), .instr_ready(rdy0),
    .instruction(ins0), .instr_pc(ipc0)
  );

  instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset_n(rst1_n),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack1), .imem_rdata(rd1),
    .branch_valid(br1), .branch_target(tg1),
    .instr_valid(v1), .instr_ready(rdy1),
    .instruction(ins1), .instr_pc(ipc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("%s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    ack0 = 1'b0; ack1 = 1'b0;
    rd0 = '0; rd1 = '0;
    br0 = 1'b0; br1 = 1'b0;
    tg0 = '0; tg1 = '0;
    rdy0 = 1'b0; rdy1 = 1'b0;
    step(); step(); step();

    chk("rst_req", {31'b0, req0}, 32'h0);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_valid", {31'b0, v0}, 32'h0);
    chk("rst_instr", ins0, 32'h0);
    chk("rst_ipc", ipc0, 32'h0);
    chk("rst1_addr", addr1, 32'hFFFF_FFFC);

    rst0_n = 1'b1;
    step();
    chk("first_req", {31'b0, req0}, 32'h1);
    chk("first_addr", addr0, 32'h0);
    chk("first_valid", {31'b0, v0}, 32'h0);

    ack0 = 1'b1; rd0 = 32'h1234_5678;
    step();
    ack0 = 1'b0;
    chk("w0_valid", {31'b0, v0}, 32'h1);
    chk("w0_instr", ins0, 32'h1234_5678);
    chk("w0_ipc", ipc0, 32'h0);
    chk("w0_req", {31'b0, req0}, 32'h0);

    // Stall in HOLD; a stray ack with no request must be ignored.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        ack0 = 1'b1; rd0 = 32'hFFFF_0000;
      end
      step();
      ack0 = 1'b0;
      chk("stall_valid", {31'b0, v0}, 32'h1);
      chk("stall_instr", ins0, 32'h1234_5678);
      chk("stall_req", {31'b0, req0}, 32'h0);
    end

    rdy0 = 1'b1;
    step();
    rdy0 = 1'b0;
    chk("acc_valid", {31'b0, v0}, 32'h0);
    chk("acc_req", {31'b0, req0}, 32'h1);
    chk("acc_addr", addr0, 32'h4);

    // Branch to 0x103 while fetch of 0x4 waits for a 3-cycle ack.
    br0 = 1'b1; tg0 = 32'h0000_0103;
    step();
    br0 = 1'b0;
    chk("sq_req", {31'b0, req0}, 32'h1);
    chk("sq_addr_hold", addr0, 32'h4);
    step();
    chk("sq_addr_hold2", addr0, 32'h4);
    ack0 = 1'b1; rd0 = 32'hDEAD_BEEF;
    step();
    ack0 = 1'b0;
    chk("sq_valid", {31'b0, v0}, 32'h0);
    chk("sq_req2", {31'b0, req0}, 32'h1);
    chk("sq_new_addr", addr0, 32'h100);
    chk("sq_instr", ins0, 32'h1234_5678);

    ack0 = 1'b1; rd0 = 32'h0BAD_F00D;
    step();
    ack0 = 1'b0;
    chk("t100_valid", {31'b0, v0}, 32'h1);
    chk("t100_instr", ins0, 32'h0BAD_F00D);
    chk("t100_ipc", ipc0, 32'h100);

    // Branch in HOLD with ready high: held word is dropped.
    br0 = 1'b1; tg0 = 32'h0000_0200; rdy0 = 1'b1;
    step();
    br0 = 1'b0; rdy0 = 1'b0;
    chk("bh_valid", {31'b0, v0}, 32'h0);
    chk("bh_req", {31'b0, req0}, 32'h1);
    chk("bh_addr", addr0, 32'h200);

    // Branch and ack in the same FETCH cycle.
    br0 = 1'b1; tg0 = 32'h0000_0300; ack0 = 1'b1; rd0 = 32'h5555_5555;
    step();
    br0 = 1'b0; ack0 = 1'b0;
    chk("ba_valid", {31'b0, v0}, 32'h0);
    chk("ba_req", {31'b0, req0}, 32'h1);
    chk("ba_addr", addr0, 32'h300);
    ack0 = 1'b1; rd0 = 32'h6666_6666;
    step();
    ack0 = 1'b0;
    chk("t300_valid", {31'b0, v0}, 32'h1);
    chk("t300_instr", ins0, 32'h6666_6666);
    chk("t300_ipc", ipc0, 32'h300);

    rdy0 = 1'b1;
    step();
    rdy0 = 1'b0;
    chk("t304_addr", addr0, 32'h304);
    step();

    // Reset mid-FETCH, ack arrives while in reset.
    rst0_n = 1'b0;
    #1;
    chk("mr_req", {31'b0, req0}, 32'h0);
    chk("mr_addr", addr0, 32'h0);
    chk("mr_valid", {31'b0, v0}, 32'h0);
    chk("mr_instr", ins0, 32'h0);
    chk("mr_ipc", ipc0, 32'h0);
    ack0 = 1'b1; rd0 = 32'hBBBB_BBBB;
    step();
    chk("mr_ack_req", {31'b0, req0}, 32'h0);
    chk("mr_ack_valid", {31'b0, v0}, 32'h0);
    ack0 = 1'b0;
    rst0_n = 1'b1;
    #1;
    chk("rel_req", {31'b0, req0}, 32'h0);
    chk("rel_instr", ins0, 32'h0);
    step();
    chk("rel_req2", {31'b0, req0}, 32'h1);
    chk("rel_addr", addr0, 32'h0);
    ack0 = 1'b1; rd0 = 32'h7777_7777;
    step();
    ack0 = 1'b0;
    chk("rel_instr2", ins0, 32'h7777_7777);
    chk("rel_ipc", ipc0, 32'h0);

    // Wrap-around from 0xFFFF_FFFC.
    rst1_n = 1'b1;
    step();
    chk("wr_req", {31'b0, req1}, 32'h1);
    chk("wr_addr", addr1, 32'hFFFF_FFFC);
    ack1 = 1'b1; rd1 = 32'hCAFE_0001;
    step();
    ack1 = 1'b0;
    chk("wr_valid", {31'b0, v1}, 32'h1);
    chk("wr_ipc", ipc1, 32'hFFFF_FFFC);
    chk("wr_instr", ins1, 32'hCAFE_0001);
    rdy1 = 1'b1;
    step();
    rdy1 = 1'b0;
    chk("wr_next_req", {31'b0, req1}, 32'h1);
    chk("wr_next_addr", addr1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder. Owns the program counter, issues one outstanding request at a time to instruction memory, and holds each returned 32-bit instruction word in an output register with a valid/ready handshake. Branch redirects from the datapath (BS/PS resolution) reload the PC and squash any in-flight or held instruction.

## Interface
- `PC_WIDTH`, 32: program counter and memory address width.
- `RESET_PC`, 0: first fetch address after reset; bits [1:0] must be 0.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: memory request, registered.
- `imem_addr` out PC_WIDTH: fetch address, word aligned, registered.
- `imem_ack` in 1: memory response valid; honoured only while `imem_req`=1.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `branch_valid` in 1: single-cycle redirect pulse.
- `branch_target` in PC_WIDTH: redirect address; bits [1:0] are ignored and forced to 0.
- `instr_valid` out 1: `instruction`/`instr_pc` hold a live word.
- `instr_ready` in 1: decoder accepts the word this cycle.
- `instruction` out 32: word to the decoder.
- `instr_pc` out PC_WIDTH: address of `instruction`.

## Operation
- States: IDLE, FETCH, HOLD.
- Reset values: state IDLE, pc=RESET_PC, squash=0, `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instruction`=0, `instr_pc`=0.
- IDLE → FETCH unconditionally. `imem_req`=1 and `imem_addr`=pc.
- FETCH: hold `imem_req` and `imem_addr` stable until `imem_ack`.
  - On ack with squash=0: capture `imem_rdata` into `instruction` and pc into `instr_pc`, set `instr_valid`, drop `imem_req`, then go to HOLD.
  - On ack with squash=1: discard the data, clear squash, and stay in FETCH with a new request at pc.
- HOLD: `instr_valid`=1 with outputs stable.
  - On `instr_ready`: pc ← pc+4, clear `instr_valid`, go to FETCH.
- Branch has priority over all events. pc ← {`branch_target`[PC_WIDTH-1:2], 2'b00}.
  - In HOLD: the held word is discarded even if `instr_ready`=1 that cycle. `instr_valid` goes to 0 and the state goes to FETCH at the target.
  - In FETCH without ack: set squash. The request continues unchanged until ack, because a request must not be withdrawn.
  - In FETCH with ack the same cycle: discard the data, then go to FETCH at the target with squash=0.
  - In IDLE: the target replaces RESET_PC for the first request.
- A second branch while squash=1 only updates pc. Exactly one stale ack is discarded.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFFFF_FFFC+4 = 0x0000_0000.
- Reset asserted mid-operation clears everything immediately. An outstanding memory ack arriving after reset is ignored because `imem_req`=0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Memory ack latency is ≥1 cycle after `imem_req` rises, and is sampled on the clock edge.
- Ack at edge N → `instr_valid`=1 from edge N.
- `instr_ready` at edge M → `instr_valid`=0 and `imem_req`=1 from edge M, at address pc+4.
- Sustained throughput with ack latency 1 and ready always high is one instruction per 2 cycles.
- Branch at edge B → `instr_valid`=0 from edge B. The next `imem_req` at the target starts at edge B, or after the pending ack is retired.
- First `imem_req` is asserted one cycle after `reset_n` deasserts.

## Structure
- The shared package holds the state enum (IDLE/FETCH/HOLD), `PC_STEP`=4, and `INSTR_WIDTH`=32. The decoder uses the same `INSTR_WIDTH`.
- Single module, no sub-module. The PC register and next-PC mux stay inline.

## Test plan
- Reset release with RESET_PC=0 and ack latency 1 returning 0x12345678 → `imem_addr`=0, then `instr_valid`=1, `instruction`=0x12345678, `instr_pc`=0.
- Hold `instr_ready` low for 5 cycles in HOLD → outputs stable and `imem_req`=0. Raise ready → next request at addr 0x4.
- Branch to 0x100 while in HOLD with `instr_ready`=1 → held word never accepted, `instr_valid` drops, next request at addr 0x100.
- Branch to 0x103 while waiting for a 3-cycle ack of addr 0x4 returning 0xDEADBEEF → 0xDEADBEEF is never presented, next request at addr 0x100.
- RESET_PC=0xFFFF_FFFC, first word accepted → next request at addr 0x0.
- Assert `reset_n` low during FETCH, then ack arrives during reset → ignored. After release, the first request is at RESET_PC and all outputs hold their reset values until then.
